serial_audio_format_controller: RTL

SERIAL_AUDIO_FORMAT_CONTROLLER -- requirements
Module: serial_audio_format_controller

---
 rtl/serial_audio_pkg.sv | 35 +++
 rtl/sa_toggle_counter.sv | 41 ++++
 rtl/serial_audio_format_controller.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/serial_audio_pkg.sv
// Shared definitions for the serial audio format hunter and the decoder top:
// FSM state encoding, configuration index type and its format decoding.
package serial_audio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET_DEC = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_CHECK     = 3'd3,
    ST_LOCKED    = 3'd4
  } sa_state_e;

  typedef logic [1:0] cfg_idx_t;

  // Configuration table: bit 1 selects left-justified, bit 0 selects LRCLK polarity.
  localparam cfg_idx_t CFG_I2S_POL0 = 2'd0;
  localparam cfg_idx_t CFG_I2S_POL1 = 2'd1;
  localparam cfg_idx_t CFG_LJ_POL0  = 2'd2;
  localparam cfg_idx_t CFG_LJ_POL1  = 2'd3;
  localparam cfg_idx_t CFG_RESET    = CFG_I2S_POL0;

  function automatic logic cfg_is_i2s(input cfg_idx_t cfg);
    return ~cfg[1];
  endfunction

  function automatic logic cfg_polarity(input cfg_idx_t cfg);
    return cfg[0];
  endfunction

  // Next configuration to try after a failed hunt; wraps 3 -> 0.
  function automatic cfg_idx_t cfg_next(input cfg_idx_t cfg);
    return cfg + 2'd1;
  endfunction

endpackage

// File: rtl/sa_toggle_counter.sv
// LRCLK (dec_is_left) edge detector plus half-frame counter.
// While clear is high the reference level follows the input and the count is
// zero, so the first counted edge is relative to the level seen at the last
// cleared cycle.
module sa_toggle_counter #(
  parameter int CNT_W = 5
) (
  input  logic             sclk,
  input  logic             reset,
  input  logic             clear,
  input  logic             count_en,
  input  logic             level,
  output logic             toggle,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             level_r;
  logic [CNT_W-1:0] count_r;

  assign toggle = (level != level_r);
  assign count  = count_r;

  // Track the previous level and count qualified level changes, saturating.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      level_r <= 1'b0;
      count_r <= '0;
    end else if (clear) begin
      level_r <= level;
      count_r <= '0;
    end else begin
      level_r <= level;
      if (count_en && toggle && (count_r != CNT_MAX)) begin
        count_r <= count_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/serial_audio_format_controller.sv
// Hunts through the four serial audio formats (I2S/LJ x LRCLK polarity) by
// resetting the decoder, letting it settle, and watching for a run of
// error-free LRCLK half-frames. Holds the winning format while locked and
// retries the same format if the decoder later reports an error.
module serial_audio_format_controller
  import serial_audio_pkg::*;
#(
  parameter int RESET_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 128,
  parameter int LOCK_FRAMES   = 8,
  parameter int HUNT_TIMEOUT  = 4096
) (
  input  logic       sclk,
  input  logic       reset,
  input  logic       enable,
  input  logic       force_cfg_valid,
  input  logic [1:0] force_cfg,
  input  logic       dec_is_error,
  input  logic       dec_is_left,
  output logic       dec_reset,
  output logic       is_i2s,
  output logic       lrclk_polarity,
  output logic [1:0] cfg_index,
  output logic       locked,
  output logic       lock_lost
);

  localparam int LOCK_TOGGLES = 2 * LOCK_FRAMES;
  localparam int TOG_W        = $clog2(LOCK_TOGGLES + 1);
  localparam int MAX_WAIT     = (HUNT_TIMEOUT > SETTLE_CYCLES) ?
                                ((HUNT_TIMEOUT > RESET_CYCLES) ? HUNT_TIMEOUT : RESET_CYCLES) :
                                ((SETTLE_CYCLES > RESET_CYCLES) ? SETTLE_CYCLES : RESET_CYCLES);
  localparam int CNT_W        = $clog2(MAX_WAIT + 1);

  localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HUNT_LAST   = CNT_W'(HUNT_TIMEOUT - 1);
  localparam logic [TOG_W-1:0] TOG_LAST    = TOG_W'(LOCK_TOGGLES - 1);

  sa_state_e        state_r;
  logic [CNT_W-1:0] cnt_r;
  cfg_idx_t         cfg_r;
  logic             dec_reset_r;
  logic             is_i2s_r;
  logic             polarity_r;
  logic             locked_r;
  logic             lock_lost_r;

  logic             tog_clear_s;
  logic             tog_en_s;
  logic             toggle_s;
  logic [TOG_W-1:0] tog_count_s;
  logic             lock_hit_s;
  logic             timeout_hit_s;
  cfg_idx_t         entry_cfg_s;

  sa_toggle_counter #(
    .CNT_W (TOG_W)
  ) u_toggle_counter (
    .sclk     (sclk),
    .reset    (reset),
    .clear    (tog_clear_s),
    .count_en (tog_en_s),
    .level    (dec_is_left),
    .toggle   (toggle_s),
    .count    (tog_count_s)
  );

  // Counter handshakes and the configuration loaded on the next RESET_DEC entry.
  always_comb begin
    tog_clear_s   = (state_r != ST_CHECK) || !enable;
    tog_en_s      = (state_r == ST_CHECK) && !dec_is_error;
    lock_hit_s    = toggle_s && (tog_count_s == TOG_LAST);
    timeout_hit_s = (cnt_r == HUNT_LAST);
    if (force_cfg_valid) begin
      entry_cfg_s = force_cfg;
    end else if (state_r == ST_CHECK) begin
      entry_cfg_s = cfg_next(cfg_r);
    end else begin
      entry_cfg_s = cfg_r;
    end
  end

  // Hunt/track FSM with all decoder-facing outputs registered.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      cfg_r       <= CFG_RESET;
      dec_reset_r <= 1'b1;
      is_i2s_r    <= cfg_is_i2s(CFG_RESET);
      polarity_r  <= cfg_polarity(CFG_RESET);
      locked_r    <= 1'b0;
      lock_lost_r <= 1'b0;
    end else if (!enable) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      dec_reset_r <= 1'b1;
      locked_r    <= 1'b0;
      lock_lost_r <= 1'b0;
    end else begin
      lock_lost_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          state_r     <= ST_RESET_DEC;
          cnt_r       <= '0;
          dec_reset_r <= 1'b1;
          cfg_r       <= entry_cfg_s;
          is_i2s_r    <= cfg_is_i2s(entry_cfg_s);
          polarity_r  <= cfg_polarity(entry_cfg_s);
        end
        ST_RESET_DEC: begin
          if (cnt_r == RESET_LAST) begin
            state_r     <= ST_SETTLE;
            cnt_r       <= '0;
            dec_reset_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          // Decoder errors are meaningless while it is still settling.
          if (cnt_r == SETTLE_LAST) begin
            state_r <= ST_CHECK;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_CHECK: begin
          // Error beats lock; lock beats timeout; error and timeout share one advance.
          if (dec_is_error || (timeout_hit_s && !lock_hit_s)) begin
            state_r     <= ST_RESET_DEC;
            cnt_r       <= '0;
            dec_reset_r <= 1'b1;
            cfg_r       <= entry_cfg_s;
            is_i2s_r    <= cfg_is_i2s(entry_cfg_s);
            polarity_r  <= cfg_polarity(entry_cfg_s);
          end else if (lock_hit_s) begin
            state_r  <= ST_LOCKED;
            cnt_r    <= '0;
            locked_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_LOCKED: begin
          if (dec_is_error) begin
            state_r     <= ST_RESET_DEC;
            cnt_r       <= '0;
            dec_reset_r <= 1'b1;
            locked_r    <= 1'b0;
            lock_lost_r <= 1'b1;
            cfg_r       <= entry_cfg_s;
            is_i2s_r    <= cfg_is_i2s(entry_cfg_s);
            polarity_r  <= cfg_polarity(entry_cfg_s);
          end else begin
            state_r <= ST_LOCKED;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= '0;
          dec_reset_r <= 1'b1;
          locked_r    <= 1'b0;
        end
      endcase
    end
  end

  assign dec_reset      = dec_reset_r;
  assign is_i2s         = is_i2s_r;
  assign lrclk_polarity = polarity_r;
  assign cfg_index      = cfg_r;
  assign locked         = locked_r;
  assign lock_lost      = lock_lost_r;

endmodule
